// File: rtl/lives_hud.sv
// Lives counter with blinking-loss icon row composited over the top HUD band.
// Optional LIVES_HUD_GAMEOVER_FLASH_EN: band background flashes while game over.
module lives_hud #(
   parameter int          MAX_LIVES     = 7,
   parameter int          INIT_LIVES    = 3,
   parameter int          ICON_W        = 5,
   parameter int          ICON_PITCH    = 10,
   parameter int          X0            = 10,
   parameter int          Y0            = 5,
   parameter int          BAND_H        = 10,
   parameter logic [2:0]  ICON_RGB      = 3'b000,
   parameter logic [2:0]  BAND_RGB      = 3'b111,
   parameter int          BLINK_HALF    = 8,
   parameter int          BLINK_TOGGLES = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       life_lost,
   input  logic       life_gain,
   input  logic       restart,
   input  logic       video_on,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [2:0] rgb_in,
   output logic [2:0] rgb_out,
   output logic [3:0] lives,
   output logic       game_over
);

   localparam int TW  = $clog2(BLINK_HALF + 1);
   localparam int TGW = $clog2(BLINK_TOGGLES + 1);

   typedef enum logic {S_IDLE, S_BLINK} state_t;

   state_t           r_state;
   logic [3:0]       r_lives;
   logic [3:0]       r_blink_idx;
   logic             r_vis;
   logic [TW-1:0]    r_tick_cnt;
   logic [TGW-1:0]   r_tog_cnt;
   logic             r_game_over;
   logic [2:0]       r_rgb;

   logic             w_loss_eff;
   logic             w_gain_eff;
   logic [3:0]       w_lives_nxt;
   logic             w_half_end;
   logic             w_tick_run;
   logic             w_hit;
   logic [2:0]       w_band;
   logic [31:0]      w_xe;
   logic [31:0]      w_ye;

   assign w_xe = {22'd0, x};
   assign w_ye = {22'd0, y};

   always_comb begin
      w_loss_eff  = life_lost & ~life_gain & ~restart & (r_lives != 4'd0);
      w_gain_eff  = life_gain & ~life_lost & ~restart
                    & (r_lives < 4'(MAX_LIVES));
      w_lives_nxt = r_lives;
      if (restart)         w_lives_nxt = 4'(INIT_LIVES);
      else if (w_loss_eff) w_lives_nxt = r_lives - 4'd1;
      else if (w_gain_eff) w_lives_nxt = r_lives + 4'd1;
      w_half_end  = r_tick_cnt == TW'(BLINK_HALF - 1);
   end

`ifdef LIVES_HUD_GAMEOVER_FLASH_EN
   logic r_flash;

   // tick_cnt also paces the band flash while the game is over
   assign w_tick_run = (r_state == S_BLINK) | r_game_over;
   assign w_band     = r_flash ? ICON_RGB : BAND_RGB;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_flash <= 1'b0;
      else if (w_lives_nxt != 4'd0 || w_loss_eff)
         r_flash <= 1'b0;
      else if (frame_tick && w_half_end && w_tick_run)
         r_flash <= ~r_flash;
   end
`else
   assign w_tick_run = r_state == S_BLINK;
   assign w_band     = BAND_RGB;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_lives     <= 4'(INIT_LIVES);
         r_game_over <= 1'b0;
         r_blink_idx <= 4'd0;
         r_vis       <= 1'b0;
         r_tick_cnt  <= '0;
         r_tog_cnt   <= '0;
      end else begin
         r_lives     <= w_lives_nxt;
         r_game_over <= w_lives_nxt == 4'd0;
         if (restart || w_gain_eff) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_tog_cnt  <= '0;
         end else if (w_loss_eff) begin
            r_state     <= S_BLINK;
            r_blink_idx <= w_lives_nxt;
            r_vis       <= 1'b1;
            r_tick_cnt  <= '0;
            r_tog_cnt   <= '0;
         end else if (frame_tick && w_tick_run) begin
            if (w_half_end) begin
               r_tick_cnt <= '0;
               if (r_state == S_BLINK) begin
                  r_vis     <= ~r_vis;
                  r_tog_cnt <= r_tog_cnt + TGW'(1);
                  if (r_tog_cnt == TGW'(BLINK_TOGGLES - 1))
                     r_state <= S_IDLE;
               end
            end else begin
               r_tick_cnt <= r_tick_cnt + TW'(1);
            end
         end
      end
   end

   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < MAX_LIVES; i++) begin
         w_hit = w_hit
            | ((w_xe >= 32'(X0 + i * ICON_PITCH))
            & (w_xe <= 32'(X0 + i * ICON_PITCH + ICON_W))
            & (w_ye >= 32'(Y0))
            & (w_ye <= 32'(Y0 + ICON_W))
            & ((32'(i) < {28'd0, r_lives})
               | ((r_state == S_BLINK)
                  & (32'(i) == {28'd0, r_blink_idx})
                  & r_vis)));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_rgb <= 3'b000;
      else if (!video_on)
         r_rgb <= 3'b000;
      else if (w_hit)
         r_rgb <= ICON_RGB;
      else if (w_ye <= 32'(BAND_H))
         r_rgb <= w_band;
      else
         r_rgb <= rgb_in;
   end

   assign rgb_out   = r_rgb;
   assign lives     = r_lives;
   assign game_over = r_game_over;

endmodule

// File: tb/tb_lives_hud.sv
// Directed bench for lives_hud: abstract per-cycle model plus literal pins.
module tb_lives_hud;

   localparam int         MAX_LIVES     = 7;
   localparam int         INIT_LIVES    = 3;
   localparam int         ICON_W        = 5;
   localparam int         ICON_PITCH    = 10;
   localparam int         X0            = 10;
   localparam int         Y0            = 5;
   localparam int         BAND_H        = 10;
   localparam logic [2:0] ICON_RGB      = 3'b000;
   localparam logic [2:0] BAND_RGB      = 3'b111;
   localparam int         BLINK_HALF    = 8;
   localparam int         BLINK_TOGGLES = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick, life_lost, life_gain, restart, video_on;
   logic [9:0] x, y;
   logic [2:0] rgb_in, rgb_out;
   logic [3:0] lives;
   logic       game_over;

   int checks = 0;
   int failures = 0;

   lives_hud #(
      .MAX_LIVES(MAX_LIVES), .INIT_LIVES(INIT_LIVES), .ICON_W(ICON_W),
      .ICON_PITCH(ICON_PITCH), .X0(X0), .Y0(Y0), .BAND_H(BAND_H),
      .ICON_RGB(ICON_RGB), .BAND_RGB(BAND_RGB),
      .BLINK_HALF(BLINK_HALF), .BLINK_TOGGLES(BLINK_TOGGLES)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .life_lost(life_lost), .life_gain(life_gain), .restart(restart),
      .video_on(video_on), .x(x), .y(y), .rgb_in(rgb_in),
      .rgb_out(rgb_out), .lives(lives), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state: plain counts of frames elapsed since events.
   int   m_lives, m_bidx, m_bt, m_gt;
   bit   m_go, m_bact;
   logic [2:0] m_rgb;

   function automatic int nxt_lives(int l, bit lo, bit ga, bit rs);
      if (rs) return INIT_LIVES;
      if (lo && ga) return l;
      if (lo && l > 0) return l - 1;
      if (ga && l < MAX_LIVES) return l + 1;
      return l;
   endfunction

   function automatic logic [2:0] exp_pix(int xx, int yy, bit vid,
      logic [2:0] rin, int lv, bit bact, int bidx, int bt, int gt, bit go);
      int s;
      bit lit_hit;
      logic [2:0] band;
      if (!vid) return 3'b000;
      lit_hit = 0;
      if (xx >= X0 && yy >= Y0 && yy <= Y0 + ICON_W) begin
         s = (xx - X0) / ICON_PITCH;
         if ((xx - X0) % ICON_PITCH <= ICON_W && s < MAX_LIVES)
            lit_hit = (s < lv) ||
               (bact && s == bidx && ((bt / BLINK_HALF) % 2 == 0));
      end
      band = BAND_RGB;
`ifdef LIVES_HUD_GAMEOVER_FLASH_EN
      if (go && ((gt / BLINK_HALF) % 2 == 1)) band = ICON_RGB;
`endif
      if (lit_hit) return ICON_RGB;
      if (yy <= BAND_H) return band;
      return rin;
   endfunction

   logic m_loss, m_gain;
   assign m_loss = life_lost && !life_gain && !restart && m_lives > 0;
   assign m_gain = life_gain && !life_lost && !restart && m_lives < MAX_LIVES;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_lives <= INIT_LIVES;
         m_go    <= 1'b0;
         m_bact  <= 1'b0;
         m_bidx  <= 0;
         m_bt    <= 0;
         m_gt    <= 0;
         m_rgb   <= 3'b000;
      end else begin
         m_rgb   <= exp_pix(int'(x), int'(y), video_on, rgb_in, m_lives,
                            m_bact, m_bidx, m_bt, m_gt, m_go);
         m_lives <= nxt_lives(m_lives, life_lost, life_gain, restart);
         m_go    <= nxt_lives(m_lives, life_lost, life_gain, restart) == 0;
         if (restart || m_gain) begin
            m_bact <= 1'b0;
         end else if (m_loss) begin
            m_bact <= 1'b1;
            m_bidx <= m_lives - 1;
            m_bt   <= 0;
         end else if (m_bact && frame_tick) begin
            if (m_bt + 1 == BLINK_HALF * BLINK_TOGGLES) m_bact <= 1'b0;
            m_bt <= m_bt + 1;
         end
         if (restart || m_loss || m_gain) m_gt <= 0;
         else if (frame_tick) m_gt <= m_gt + 1;
      end
   end

   always @(negedge clk) begin
      chk("model_rgb", int'(rgb_out), int'(m_rgb));
      chk("model_lives", int'(lives), m_lives);
      chk("model_go", int'(game_over), int'(m_go));
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input bit lo, input bit ga, input bit rs, input bit ft);
      life_lost  = lo;
      life_gain  = ga;
      restart    = rs;
      frame_tick = ft;
      step(1);
      life_lost  = 0;
      life_gain  = 0;
      restart    = 0;
      frame_tick = 0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         pulse(0, 0, 0, 1);
         step(1);
      end
   endtask

   task automatic pix(input int xx, input int yy);
      x = 10'(xx);
      y = 10'(yy);
      step(1);
   endtask

   logic [2:0] fl_a, fl_b;

   initial begin
      frame_tick = 0; life_lost = 0; life_gain = 0; restart = 0;
      video_on = 1; x = 10'd10; y = 10'd5; rgb_in = 3'b000;
      reset = 0;
      #1 reset = 1;
      #7;
      chk("rst_rgb", int'(rgb_out), 0);
      chk("rst_lives", int'(lives), 3);
      chk("rst_go", int'(game_over), 0);
      #4 reset = 0;

      step(2);
      chk("slot0_lit", int'(rgb_out), 0);
      pix(30, 5);
      chk("slot2_lit", int'(rgb_out), 0);
      pix(40, 5);
      chk("slot3_band", int'(rgb_out), 7);
      chk("lives_init", int'(lives), 3);

      pulse(1, 0, 0, 0);
      chk("loss_lives", int'(lives), 2);
      pix(30, 5);
      chk("blink_vis0", int'(rgb_out), 0);
      ticks(8);
      chk("blink_off", int'(rgb_out), 7);
      ticks(8);
      chk("blink_on", int'(rgb_out), 0);
      ticks(32);
      chk("blink_done", int'(rgb_out), 7);

      pulse(1, 0, 0, 0);
      chk("chain_l1", int'(lives), 1);
      pulse(1, 0, 0, 0);
      chk("chain_l0", int'(lives), 0);
      chk("chain_go", int'(game_over), 1);
      pulse(1, 0, 0, 0);
      chk("chain_hold", int'(lives), 0);
      chk("chain_go_hold", int'(game_over), 1);

`ifdef LIVES_HUD_GAMEOVER_FLASH_EN
      fl_a = 3'b111; fl_b = 3'b000;
`else
      fl_a = 3'b111; fl_b = 3'b111;
`endif
      pix(300, 2);
      ticks(4);
      chk("flash_early", int'(rgb_out), int'(fl_a));
      ticks(4);
      chk("flash_late", int'(rgb_out), int'(fl_b));
      ticks(8);

      pulse(1, 0, 1, 0);
      chk("restart_lives", int'(lives), 3);
      chk("restart_go", int'(game_over), 0);
      rgb_in = 3'b101;
      pix(100, 200);
      chk("pass_through", int'(rgb_out), 5);
      video_on = 0;
      step(1);
      chk("video_off", int'(rgb_out), 0);
      video_on = 1;

      pulse(1, 1, 0, 0);
      chk("lost_gain_same", int'(lives), 3);
      repeat (5) pulse(0, 1, 0, 0);
      chk("gain_sat", int'(lives), 7);
      pix(70, 5);
      chk("slot6_left", int'(rgb_out), 0);
      pix(75, 5);
      chk("slot6_right", int'(rgb_out), 0);
      pix(76, 5);
      chk("slot6_past", int'(rgb_out), 7);
      pix(70, 11);
      chk("below_band", int'(rgb_out), 5);
      pix(9, 5);
      chk("left_of_x0", int'(rgb_out), 7);

      pix(70, 5);
      pulse(1, 0, 0, 1);
      ticks(3);
      pulse(1, 0, 0, 0);
      pix(60, 10);
      ticks(9);
      pulse(1, 1, 0, 1);
      ticks(2);
      pulse(0, 1, 0, 0);
      ticks(10);
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lives_hud.md
Name: lives_hud

Overview:
- Parametrised lives indicator overlay for the VGA game pipeline. Owns the player's life counter and renders the counter as a row of square icons in the top HUD band.
- Pixels outside the HUD band pass through from upstream. Sits between the playfield renderer and the VGA output stage.
- Adds over the previous indicator: a registered life counter with gain/loss/restart events, a blink animation on life loss, a game-over flag, and a registered pixel path.

Parameters:
- MAX_LIVES, 7, number of icon slots; 1..15.
- INIT_LIVES, 3, counter value after reset or restart; must be ≤ MAX_LIVES.
- ICON_W, 5, icon edge length minus 1. Icon spans ICON_W+1 pixels, bounds inclusive.
- ICON_PITCH, 10, x distance between consecutive icon origins; must be > ICON_W.
- X0, 10, x origin of icon 0.
- Y0, 5, y origin of all icons.
- BAND_H, 10, HUD band covers y = 0..BAND_H inclusive.
- ICON_RGB, 3'b000, colour of a lit icon.
- BAND_RGB, 3'b111, colour of the band background.
- BLINK_HALF, 8, frame ticks per blink half-period; ≥ 1.
- BLINK_TOGGLES, 6, number of visibility toggles per blink sequence; even, ≥ 2.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, asserted at the start of vertical blanking
- life_lost  in  1  one-cycle pulse requesting a decrement
- life_gain  in  1  one-cycle pulse requesting an increment
- restart  in  1  one-cycle pulse that reloads INIT_LIVES
- video_on  in  1  active-video qualifier for x and y
- x  in  10  current pixel column, 0..639
- y  in  10  current pixel row, 0..479
- rgb_in  in  3  upstream pixel colour
- rgb_out  out  3  composited pixel colour, registered
- lives  out  4  current life count, registered; unused upper bits are 0
- game_over  out  1  high while lives == 0, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: lives = INIT_LIVES, game_over = 0, rgb_out = 0, blink FSM in IDLE, blink counters 0.

Counter update, evaluated each clk edge in priority order:
1. restart: lives ← INIT_LIVES, game_over ← 0, FSM ← IDLE. life_lost and life_gain in the same cycle are ignored.
2. life_lost and life_gain in the same cycle: no change.
3. life_lost with lives > 0: lives ← lives−1. Start the blink on slot index = new lives value.
4. life_lost with lives == 0: ignored.
5. life_gain with lives < MAX_LIVES: lives ← lives+1. Cancels any blink (FSM ← IDLE).
6. life_gain with lives == MAX_LIVES: ignored.
- game_over updates on the same edge as lives: it equals (next lives == 0).

Blink FSM:
- IDLE:
  - On an effective loss → BLINK, with blink_idx ← new lives, vis ← 1, tick_cnt ← 0, tog_cnt ← 0.
- BLINK:
  - On each frame_tick, tick_cnt increments.
  - When tick_cnt reaches BLINK_HALF−1 on a frame_tick: tick_cnt ← 0, vis toggles, tog_cnt increments.
  - When tog_cnt reaches BLINK_TOGGLES → IDLE.
  - A further effective loss in BLINK restarts the sequence on the new index.
  - frame_tick coinciding with a loss: the restart wins.

Pixel path, one-cycle latency (inputs at edge n produce rgb_out after edge n+1):
- Slot i hit: X0+i·ICON_PITCH ≤ x ≤ X0+i·ICON_PITCH+ICON_W and Y0 ≤ y ≤ Y0+ICON_W.
- Slot i lit: i < lives, or (FSM == BLINK and i == blink_idx and vis).
- Output selection:
  - video_on = 0 → 0.
  - Lit slot hit → ICON_RGB.
  - y ≤ BAND_H → BAND_RGB.
  - Otherwise → rgb_in.
- Slot geometry is combinational over i = 0..MAX_LIVES−1; no division is used.
- A change of lives takes effect on the pixel path from the cycle after the update edge.

Optional Feature:
- Macro: LIVES_HUD_GAMEOVER_FLASH_EN.
- Defined: while game_over = 1, the band background alternates between BAND_RGB and ICON_RGB, toggling every BLINK_HALF frame ticks. It reuses tick_cnt, starts at BAND_RGB, and stops and resets on restart.
- Undefined: the band is static BAND_RGB in game over; no extra logic.

Test Plan:
- Reset release, default parameters, x=10, y=5, video_on=1 → rgb_out=000 two cycles later; x=30,y=5 → 000; x=40,y=5 → 111; lives=3, game_over=0.
- One life_lost pulse → lives=2 next edge. Pixel x=30,y=5: after 8 frame_ticks 111, after 16 000. After 48 ticks the FSM is IDLE and the pixel is 111.
- Three life_lost pulses, then a fourth → lives 2,1,0,0; game_over=1 on the third edge and held after the fourth.
- life_lost and life_gain in the same cycle at lives=3 → lives stays 3, no blink started. life_gain ×5 from 3 → lives saturates at 7.
- restart together with life_lost at lives=0 → lives=3, game_over=0, FSM IDLE. Pixel x=100,y=200 with rgb_in=101 → rgb_out=101; same pixel with video_on=0 → 000.
- With LIVES_HUD_GAMEOVER_FLASH_EN, at lives=0 → pixel x=300,y=2 reads 111 for ticks 0–7 and 000 for ticks 8–15. Without the macro → constant 111.
